// File: rtl/md_unit_param.sv
// Parametrised HI/LO multiply/divide unit for the E stage.
// Supports mult/div ops, MADD/MSUB accumulation, cancel, and direct HI/LO writes.
module md_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hilo_sel,
  input  logic             hilo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             busy_stall
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_r;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;

  logic               op_valid_s;
  logic               div_start_s;
  logic               signed_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] acc_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH-1:0]   div_b_s;
  logic [WIDTH-1:0]   quo_mag_s;
  logic [WIDTH-1:0]   rem_mag_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [2*WIDTH-1:0] res_s;

  assign op_valid_s  = (start >= OP_MULTU) && (start <= OP_MSUB);
  assign div_start_s = (start == OP_DIVU) || (start == OP_DIV);

  assign rdata      = hilo_sel ? hi_r : lo_r;
  assign busy       = busy_r;
  assign busy_stall = busy_r | (start != 4'd0);

  // Result datapath on latched operands; signed divide works on magnitudes so MIN/-1 wraps to MIN.
  always_comb begin
    signed_s = (op_r == OP_MULT) || (op_r == OP_DIV) || (op_r == OP_MADD) || (op_r == OP_MSUB);
    if (signed_s) begin
      ext_a_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
      ext_b_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};
    end else begin
      ext_a_s = {{WIDTH{1'b0}}, a_r};
      ext_b_s = {{WIDTH{1'b0}}, b_r};
    end
    prod_s  = ext_a_s * ext_b_s;
    acc_s   = {hi_r, lo_r};
    neg_a_s = signed_s & a_r[WIDTH-1];
    neg_b_s = signed_s & b_r[WIDTH-1];
    mag_a_s = neg_a_s ? -a_r : a_r;
    mag_b_s = neg_b_s ? -b_r : b_r;
    if (mag_b_s == {WIDTH{1'b0}}) begin
      div_b_s = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      div_b_s = mag_b_s;
    end
    quo_mag_s = mag_a_s / div_b_s;
    rem_mag_s = mag_a_s % div_b_s;
    quo_s     = (neg_a_s ^ neg_b_s) ? -quo_mag_s : quo_mag_s;
    rem_s     = neg_a_s ? -rem_mag_s : rem_mag_s;
    case (op_r)
      OP_MULTU, OP_MULT: res_s = prod_s;
      OP_MADDU, OP_MADD: res_s = acc_s + prod_s;
      OP_MSUBU, OP_MSUB: res_s = acc_s - prod_s;
      OP_DIVU, OP_DIV: begin
        if (b_r == {WIDTH{1'b0}}) begin
          res_s = {a_r, {WIDTH{1'b1}}};
        end else begin
          res_s = {rem_s, quo_s};
        end
      end
      default: res_s = acc_s;
    endcase
  end

  // Control FSM, latency counter, operand latches and HI/LO state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      op_r    <= 4'd0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_valid_s && !cancel) begin
            op_r    <= start;
            a_r     <= src_a;
            b_r     <= src_b;
            cnt_r   <= div_start_s ? DIV_LOAD : MULT_LOAD;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else if (hilo_we && (start == 4'd0)) begin
            if (hilo_sel) begin
              hi_r <= wdata;
            end else begin
              lo_r <= wdata;
            end
          end
        end
        ST_RUN: begin
          if (cancel) begin
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (cnt_r == {CW{1'b0}}) begin
            {hi_r, lo_r} <= res_s;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          cnt_r   <= {CW{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: a default 32-bit instance and a 16-bit,
// single-cycle-multiply instance sharing clock and reset.
module tb_md_unit_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  start;
  logic [31:0] src_a, src_b, wdata, rdata;
  logic        cancel, hilo_sel, hilo_we, busy, busy_stall;

  logic [3:0]  s_start;
  logic [15:0] s_a, s_b, s_wdata, s_rdata;
  logic        s_cancel, s_hilo_sel, s_hilo_we, s_busy, s_busy_stall;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  md_unit_param dut (
    .clk(clk), .reset(reset), .start(start), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hilo_sel(hilo_sel), .hilo_we(hilo_we), .wdata(wdata),
    .rdata(rdata), .busy(busy), .busy_stall(busy_stall)
  );

  md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .src_a(s_a), .src_b(s_b),
    .cancel(s_cancel), .hilo_sel(s_hilo_sel), .hilo_we(s_hilo_we), .wdata(s_wdata),
    .rdata(s_rdata), .busy(s_busy), .busy_stall(s_busy_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    hilo_sel = 1'b1;
    #1;
    check({tag, "_hi"}, 64'(rdata), 64'(hi));
    hilo_sel = 1'b0;
    #1;
    check({tag, "_lo"}, 64'(rdata), 64'(lo));
  endtask

  task automatic write_reg(input logic sel, input logic [31:0] d);
    hilo_sel = sel;
    wdata    = d;
    hilo_we  = 1'b1;
    tick();
    hilo_we  = 1'b0;
  endtask

  // Issues an op and returns how many cycles busy stayed high (0 if never accepted).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    start = op;
    src_a = a;
    src_b = b;
    tick();
    start = 4'd0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; start = 4'd0; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
    cancel = 1'b0; hilo_sel = 1'b0; hilo_we = 1'b0;
    s_start = 4'd0; s_a = 16'd0; s_b = 16'd0; s_wdata = 16'd0;
    s_cancel = 1'b0; s_hilo_sel = 1'b0; s_hilo_we = 1'b0;

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(busy_stall), 64'd0);
    check_hilo("rst", 32'h0, 32'h0);
    start = 4'd9;
    #1;
    check("stall_on_start", 64'(busy_stall), 64'd1);
    start = 4'd0;
    @(negedge clk);
    reset = 1'b1;

    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, cyc);
    check("mult_cycles", 64'(cyc), 64'd5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_cycles", 64'(cyc), 64'd10);
    check_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd4, 32'd7, 32'hFFFF_FFFE, cyc);
    check_hilo("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(4'd3, 32'd100, 32'd7, cyc);
    check_hilo("divu_100_7", 32'd2, 32'd14);
    run_op(4'd3, 32'd7, 32'd0, cyc);
    check_hilo("divu_by0", 32'd7, 32'hFFFF_FFFF);
    run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);

    write_reg(1'b1, 32'h0);
    write_reg(1'b0, 32'hFFFF_FFFF);
    check_hilo("mthi_mtlo", 32'h0, 32'hFFFF_FFFF);
    run_op(4'd5, 32'd1, 32'd1, cyc);
    check("madd_cycles", 64'(cyc), 64'd5);
    check_hilo("maddu", 32'h1, 32'h0);
    run_op(4'd8, 32'd2, 32'd3, cyc);
    check_hilo("msub", 32'h0, 32'hFFFF_FFFA);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, cyc);
    check_hilo("madd_neg", 32'h0, 32'hFFFF_FFF9);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, cyc);
    check_hilo("maddu_big", 32'h1, 32'hFFFF_FFF8);
    run_op(4'd7, 32'd1, 32'd2, cyc);
    check_hilo("msubu", 32'h1, 32'hFFFF_FFF6);

    // Cancel in RUN cycle 4, with an mtlo attempt while busy.
    start = 4'd4; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 4'd0;
    check("cancel_busy1", 64'(busy), 64'd1);
    tick();
    tick();
    hilo_sel = 1'b0; wdata = 32'h55; hilo_we = 1'b1;
    tick();
    hilo_we = 1'b0;
    check("busy_c4", 64'(busy), 64'd1);
    check("we_busy_lo", 64'(rdata), 64'(32'hFFFF_FFF6));
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy0", 64'(busy), 64'd0);
    tick(); tick(); tick();
    check_hilo("cancel_hold", 32'h1, 32'hFFFF_FFF6);

    start = 4'd1; src_a = 32'd2; src_b = 32'd2; cancel = 1'b1;
    tick();
    start = 4'd0; cancel = 1'b0;
    check("cancel_start_rej", 64'(busy), 64'd0);
    repeat (6) tick();
    check_hilo("cancel_start_hold", 32'h1, 32'hFFFF_FFF6);

    start = 4'd2; src_a = 32'd2; src_b = 32'd2;
    tick();
    start = 4'd0;
    repeat (4) tick();
    check("last_cycle_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_commit_busy", 64'(busy), 64'd0);
    check_hilo("cancel_commit", 32'h1, 32'hFFFF_FFF6);

    // Start and mthi in the same cycle: the write must be dropped.
    write_reg(1'b1, 32'h0);
    write_reg(1'b0, 32'h0);
    start = 4'd5; src_a = 32'd3; src_b = 32'd4;
    hilo_sel = 1'b1; wdata = 32'hABCD; hilo_we = 1'b1;
    tick();
    start = 4'd0; hilo_we = 1'b0;
    check("start_we_hi", 64'(rdata), 64'd0);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
    check("start_we_cycles", 64'(cyc), 64'd5);
    check_hilo("start_we", 32'h0, 32'hC);

    run_op(4'd2, 32'd3, 32'd5, cyc);
    run_op(4'd1, 32'd6, 32'd7, cyc);
    check("b2b_cycles", 64'(cyc), 64'd5);
    check_hilo("b2b", 32'h0, 32'd42);

    // Asynchronous reset in the middle of a divide.
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check_hilo("pre_rst", 32'hFFFF_FFFE, 32'h1);
    start = 4'd4; src_a = 32'd9; src_b = 32'd2; hilo_sel = 1'b1;
    tick();
    start = 4'd0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_stall", 64'(busy_stall), 64'd0);
    check("midrst_hi", 64'(rdata), 64'd0);
    hilo_sel = 1'b0;
    #1;
    check("midrst_lo", 64'(rdata), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(4'd2, 32'd7, 32'd6, cyc);
    check_hilo("post_rst", 32'h0, 32'd42);

    // 16-bit instance: one-cycle multiply and a signed divide.
    s_start = 4'd2; s_a = 16'h8000; s_b = 16'h8000;
    tick();
    s_start = 4'd0;
    check("w16_busy1", 64'(s_busy), 64'd1);
    tick();
    check("w16_busy0", 64'(s_busy), 64'd0);
    s_hilo_sel = 1'b1;
    #1;
    check("w16_mult_hi", 64'(s_rdata), 64'h4000);
    s_hilo_sel = 1'b0;
    #1;
    check("w16_mult_lo", 64'(s_rdata), 64'h0);
    s_start = 4'd4; s_a = 16'hFFF9; s_b = 16'h0002;
    tick();
    s_start = 4'd0;
    cyc = 0;
    while (s_busy && cyc < 100) begin
      cyc++;
      tick();
    end
    check("w16_div_cycles", 64'(cyc), 64'd3);
    check("w16_div_lo", 64'(s_rdata), 64'hFFFD);
    s_hilo_sel = 1'b1;
    #1;
    check("w16_div_hi", 64'(s_rdata), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
